// File: rtl/chimera_pkg.sv
// Shared types for the Chimera cluster isolation sequencer.
// Holds the per-cluster FSM state encoding and a sizing helper.
package chimera_pkg;

    localparam int unsigned CluIsoStateWidth = 3;

    typedef enum logic [CluIsoStateWidth-1:0] {
        CLU_ACTIVE   = 3'd0,
        CLU_DRAIN    = 3'd1,
        CLU_ISOLATED = 3'd2,
        CLU_GATED    = 3'd3,
        CLU_WAKE     = 3'd4,
        CLU_RELEASE  = 3'd5
    } clu_iso_state_e;

    function automatic int unsigned clu_iso_max3(input int unsigned a,
                                                 input int unsigned b,
                                                 input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/chimera_clu_iso_ctrl_if.sv
// Isolation handshake bundle between the sequencer and the axi_isolate instances.
// Cluster c owns bits [c*NumPorts +: NumPorts] of both vectors.
interface chimera_clu_iso_ctrl_if #(
    parameter int unsigned NumClusters = 5,
    parameter int unsigned NumPorts    = 4
);
    logic [NumClusters*NumPorts-1:0] port_isolate;
    logic [NumClusters*NumPorts-1:0] port_isolated;

    modport master (output port_isolate, input port_isolated);
    modport slave  (input port_isolate, output port_isolated);
endinterface

// File: rtl/chimera_clu_iso_fsm.sv
// One cluster's drain -> gate -> reset -> wake sequencer with its dwell counter
// and sticky drain-timeout flag. All outputs come straight from flops.
module chimera_clu_iso_fsm
    import chimera_pkg::*;
#(
    parameter int unsigned NumPorts     = 4,
    parameter int unsigned DrainTimeout = 1024,
    parameter int unsigned GateDelay    = 4,
    parameter int unsigned ResetCycles  = 8,
    parameter bit          BootIsolated = 1'b0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                iso_req_i,
    input  logic [NumPorts-1:0] port_isolated_i,
    input  logic                timeout_clr_i,
    output logic [NumPorts-1:0] port_isolate_o,
    output logic                clk_en_o,
    output logic                rst_no,
    output clu_iso_state_e      state_o,
    output logic                timeout_o
);

    localparam int unsigned CntMax   = clu_iso_max3(DrainTimeout, GateDelay, ResetCycles);
    localparam int unsigned CntWidth = $clog2(CntMax + 1);

    typedef logic [CntWidth-1:0] cnt_t;

    localparam cnt_t DrainLast = cnt_t'((DrainTimeout == 0) ? 0 : DrainTimeout - 1);
    localparam cnt_t GateLast  = cnt_t'(GateDelay - 1);
    localparam cnt_t ResetLast = cnt_t'(ResetCycles - 1);

    localparam clu_iso_state_e ResetState =
        clu_iso_state_e'(BootIsolated ? CLU_GATED : CLU_ACTIVE);

    clu_iso_state_e      state_q, state_d;
    cnt_t                cnt_q, cnt_d;
    logic                timeout_q, timeout_d;
    logic [NumPorts-1:0] iso_q, iso_d;
    logic                clk_en_q, clk_en_d;
    logic                rst_n_q, rst_n_d;

    logic all_iso, none_iso, timeout_set;

    always_comb begin
        all_iso  = &port_isolated_i;
        none_iso = ~|port_isolated_i;
        state_d  = state_q;

        case (state_q)
            CLU_ACTIVE: begin
                if (iso_req_i) state_d = CLU_DRAIN;
            end
            CLU_DRAIN: begin
                // Dropping the request wins over a simultaneous drain completion.
                if (!iso_req_i)   state_d = CLU_RELEASE;
                else if (all_iso) state_d = CLU_ISOLATED;
            end
            CLU_ISOLATED: begin
                if (!iso_req_i)             state_d = CLU_RELEASE;
                else if (cnt_q == GateLast) state_d = CLU_GATED;
            end
            CLU_GATED: begin
                if (!iso_req_i) state_d = CLU_WAKE;
            end
            CLU_WAKE: begin
                if (cnt_q == ResetLast) state_d = CLU_RELEASE;
            end
            CLU_RELEASE: begin
                if (iso_req_i)     state_d = CLU_DRAIN;
                else if (none_iso) state_d = CLU_ACTIVE;
            end
            default: state_d = ResetState;
        endcase

        // Saturation keeps the timeout compare from matching twice in one visit.
        if (state_d != state_q)  cnt_d = '0;
        else if (cnt_q == '1)    cnt_d = cnt_q;
        else                     cnt_d = cnt_q + 1'b1;

        timeout_set = (DrainTimeout != 0) && (state_q == CLU_DRAIN) && (cnt_q == DrainLast);
        timeout_d   = timeout_set | (timeout_q & ~timeout_clr_i);

        // Outputs decoded from the next state so they register alongside it.
        iso_d    = '1;
        clk_en_d = 1'b1;
        rst_n_d  = 1'b1;
        case (state_d)
            CLU_ACTIVE, CLU_RELEASE: iso_d = '0;
            CLU_GATED: begin
                clk_en_d = 1'b0;
                rst_n_d  = 1'b0;
            end
            CLU_WAKE: rst_n_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ResetState;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            iso_q     <= {NumPorts{BootIsolated}};
            clk_en_q  <= ~BootIsolated;
            rst_n_q   <= ~BootIsolated;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            iso_q     <= iso_d;
            clk_en_q  <= clk_en_d;
            rst_n_q   <= rst_n_d;
        end
    end

    assign port_isolate_o = iso_q;
    assign clk_en_o       = clk_en_q;
    assign rst_no         = rst_n_q;
    assign state_o        = state_q;
    assign timeout_o      = timeout_q;

endmodule

// File: rtl/chimera_clu_iso_ctrl.sv
// Per-cluster isolation / clock-gate / reset sequencer for the cluster domain.
// Optional timeout interrupt enabled by defining CHIMERA_CLU_ISO_IRQ_EN.
module chimera_clu_iso_ctrl
    import chimera_pkg::*;
#(
    parameter int unsigned NumClusters  = 5,
    parameter int unsigned NumPorts     = 4,
    parameter int unsigned DrainTimeout = 1024,
    parameter int unsigned GateDelay    = 4,
    parameter int unsigned ResetCycles  = 8,
    parameter bit          BootIsolated = 1'b0
) (
    input  logic                                   soc_clk_i,
    input  logic                                   rst_ni,
    input  logic [NumClusters-1:0]                 iso_req_i,
    chimera_clu_iso_ctrl_if.master                 iso_port,
    output logic [NumClusters-1:0]                 clu_clk_en_o,
    output logic [NumClusters-1:0]                 clu_rst_no,
    output logic [CluIsoStateWidth*NumClusters-1:0] state_o,
    output logic [NumClusters-1:0]                 timeout_o,
    input  logic [NumClusters-1:0]                 timeout_clr_i,
    output logic                                   irq_o
);

    logic [NumClusters*NumPorts-1:0] port_isolate;

    for (genvar c = 0; c < NumClusters; c++) begin : g_clu
        clu_iso_state_e state;

        chimera_clu_iso_fsm #(
            .NumPorts     (NumPorts),
            .DrainTimeout (DrainTimeout),
            .GateDelay    (GateDelay),
            .ResetCycles  (ResetCycles),
            .BootIsolated (BootIsolated)
        ) i_fsm (
            .clk_i           (soc_clk_i),
            .rst_ni          (rst_ni),
            .iso_req_i       (iso_req_i[c]),
            .port_isolated_i (iso_port.port_isolated[c*NumPorts +: NumPorts]),
            .timeout_clr_i   (timeout_clr_i[c]),
            .port_isolate_o  (port_isolate[c*NumPorts +: NumPorts]),
            .clk_en_o        (clu_clk_en_o[c]),
            .rst_no          (clu_rst_no[c]),
            .state_o         (state),
            .timeout_o       (timeout_o[c])
        );

        assign state_o[c*CluIsoStateWidth +: CluIsoStateWidth] = state;
    end

    assign iso_port.port_isolate = port_isolate;

`ifdef CHIMERA_CLU_ISO_IRQ_EN
    logic irq_q, irq_d;

    assign irq_d = |timeout_o;

    always_ff @(posedge soc_clk_i or negedge rst_ni) begin
        if (!rst_ni) irq_q <= 1'b0;
        else         irq_q <= irq_d;
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_chimera_clu_iso_ctrl.sv
// Bench for chimera_clu_iso_ctrl: directed table, async reset sequence and
// randomized traffic checked every cycle against a dwell-time reference model.
module tb_chimera_clu_iso_ctrl;

    localparam int NC = 5;
    localparam int NP = 4;
    localparam int DT = 16;
    localparam int GD = 4;
    localparam int RC = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [NC-1:0]    req0 = '0, clr0 = '0;
    logic [NC*NP-1:0] isol0 = '0;
    logic [NC-1:0]    en0, rstn0, to0;
    logic [3*NC-1:0]  st0;
    logic             irq0;

    logic [NC-1:0]    req1 = '1, clr1 = '0;
    logic [NC*NP-1:0] isol1 = '1;
    logic [NC-1:0]    en1, rstn1, to1;
    logic [3*NC-1:0]  st1;
    logic             irq1;

    chimera_clu_iso_ctrl_if #(.NumClusters(NC), .NumPorts(NP)) if0 ();
    chimera_clu_iso_ctrl_if #(.NumClusters(NC), .NumPorts(NP)) if1 ();
    assign if0.port_isolated = isol0;
    assign if1.port_isolated = isol1;

    chimera_clu_iso_ctrl #(
        .NumClusters(NC), .NumPorts(NP), .DrainTimeout(DT),
        .GateDelay(GD), .ResetCycles(RC), .BootIsolated(1'b0)
    ) dut0 (
        .soc_clk_i(clk), .rst_ni(rst_n), .iso_req_i(req0), .iso_port(if0),
        .clu_clk_en_o(en0), .clu_rst_no(rstn0), .state_o(st0),
        .timeout_o(to0), .timeout_clr_i(clr0), .irq_o(irq0)
    );

    chimera_clu_iso_ctrl #(
        .NumClusters(NC), .NumPorts(NP), .DrainTimeout(DT),
        .GateDelay(GD), .ResetCycles(RC), .BootIsolated(1'b1)
    ) dut1 (
        .soc_clk_i(clk), .rst_ni(rst_n), .iso_req_i(req1), .iso_port(if1),
        .clu_clk_en_o(en1), .clu_rst_no(rstn1), .state_o(st1),
        .timeout_o(to1), .timeout_clr_i(clr1), .irq_o(irq1)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase per cluster plus edges spent in it.
    // Phase outputs are bit-per-phase lookup tables.
    logic [5:0] iso_tab = 6'b011110;
    logic [5:0] en_tab  = 6'b110111;
    logic [5:0] rst_tab = 6'b100111;
    int mst[NC];
    int dwell[NC];
    bit mto[NC];
    bit mirq;

    task automatic model_reset();
        for (int c = 0; c < NC; c++) begin
            mst[c] = 0; dwell[c] = 0; mto[c] = 1'b0;
        end
        mirq = 1'b0;
    endtask

    task automatic model_step();
        bit any_to;
        any_to = 1'b0;
        for (int c = 0; c < NC; c++) any_to |= mto[c];
        for (int c = 0; c < NC; c++) begin
            int nx;
            bit r, all1, all0, set;
            r    = req0[c];
            all1 = &isol0[c*NP +: NP];
            all0 = ~|isol0[c*NP +: NP];
            nx   = mst[c];
            case (mst[c])
                0: if (r) nx = 1;
                1: if (!r) nx = 5; else if (all1) nx = 2;
                2: if (!r) nx = 5; else if (dwell[c] == GD - 1) nx = 3;
                3: if (!r) nx = 4;
                4: if (dwell[c] == RC - 1) nx = 5;
                5: if (r) nx = 1; else if (all0) nx = 0;
                default: nx = 0;
            endcase
            set    = (DT != 0) && (mst[c] == 1) && (dwell[c] == DT - 1);
            mto[c] = set | (mto[c] & ~clr0[c]);
            if (nx != mst[c]) dwell[c] = 0;
            else              dwell[c] = dwell[c] + 1;
            mst[c] = nx;
        end
`ifdef CHIMERA_CLU_ISO_IRQ_EN
        mirq = any_to;
`else
        mirq = 1'b0;
`endif
    endtask

    task automatic check_model();
        logic [NC*NP-1:0] ei;
        logic [NC-1:0]    een, ern, eto;
        logic [3*NC-1:0]  es;
        for (int c = 0; c < NC; c++) begin
            ei[c*NP +: NP] = {NP{iso_tab[mst[c]]}};
            een[c]         = en_tab[mst[c]];
            ern[c]         = rst_tab[mst[c]];
            es[c*3 +: 3]   = 3'(mst[c]);
            eto[c]         = mto[c];
        end
        cmp("isolate", 64'(if0.port_isolate), 64'(ei));
        cmp("clk_en",  64'(en0),   64'(een));
        cmp("rst_n",   64'(rstn0), 64'(ern));
        cmp("state",   64'(st0),   64'(es));
        cmp("timeout", 64'(to0),   64'(eto));
        cmp("irq",     64'(irq0),  64'(mirq));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic check_boot();
        cmp("boot_state",   64'(st1),              64'({NC{3'd3}}));
        cmp("boot_isolate", 64'(if1.port_isolate), 64'({NC*NP{1'b1}}));
        cmp("boot_clk_en",  64'(en1),              64'(0));
        cmp("boot_rst_n",   64'(rstn1),            64'(0));
        cmp("boot_timeout", 64'(to1),              64'(0));
    endtask

    typedef struct {
        logic       req;
        logic [3:0] isol;
        logic       clr;
        int         n;
        int         st;
        logic       to;
    } vec_t;

    vec_t tbl[$];
    logic [NC-1:0] stuck = '0;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Cluster 2 walks through the full sequence, the timeout and the race cases.
        tbl.push_back('{1'b1, 4'h0, 1'b0, 1,  1, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 1'b0, 4,  1, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 1'b0, 1,  2, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 1'b0, 3,  2, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 1'b0, 1,  3, 1'b0});
        tbl.push_back('{1'b0, 4'hF, 1'b0, 1,  4, 1'b0});
        tbl.push_back('{1'b0, 4'hF, 1'b0, 7,  4, 1'b0});
        tbl.push_back('{1'b0, 4'hF, 1'b0, 1,  5, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 1,  0, 1'b0});
        tbl.push_back('{1'b1, 4'h7, 1'b0, 1,  1, 1'b0});
        tbl.push_back('{1'b1, 4'h7, 1'b0, 15, 1, 1'b0});
        tbl.push_back('{1'b1, 4'h7, 1'b0, 1,  1, 1'b1});
        tbl.push_back('{1'b1, 4'h7, 1'b0, 1,  1, 1'b1});
        tbl.push_back('{1'b1, 4'h7, 1'b1, 1,  1, 1'b0});
        tbl.push_back('{1'b1, 4'h7, 1'b0, 20, 1, 1'b0});
        tbl.push_back('{1'b0, 4'hF, 1'b0, 1,  5, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 1,  0, 1'b0});
        tbl.push_back('{1'b1, 4'h0, 1'b0, 1,  1, 1'b0});
        tbl.push_back('{1'b1, 4'hF, 1'b0, 1,  2, 1'b0});
        tbl.push_back('{1'b0, 4'hF, 1'b0, 1,  5, 1'b0});
        tbl.push_back('{1'b0, 4'h0, 1'b0, 1,  0, 1'b0});

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_model();
        cmp("reset_state",  64'(st0),              64'(0));
        cmp("reset_clk_en", 64'(en0),              64'({NC{1'b1}}));
        cmp("reset_rst_n",  64'(rstn0),            64'({NC{1'b1}}));
        cmp("reset_iso",    64'(if0.port_isolate), 64'(0));
        check_boot();
        #2 rst_n = 1'b1;

        foreach (tbl[i]) begin
            req0[2]          = tbl[i].req;
            isol0[2*NP +: NP] = tbl[i].isol;
            clr0[2]          = tbl[i].clr;
            for (int k = 0; k < tbl[i].n; k++) begin
                tick();
                clr0[2] = 1'b0;
            end
            cmp($sformatf("tbl%0d_state", i), 64'(st0[6 +: 3]), 64'(tbl[i].st));
            cmp($sformatf("tbl%0d_to", i),    64'(to0[2]),       64'(tbl[i].to));
        end
        check_boot();

        // Drive cluster 2 into WAKE, then pull the async reset between edges.
        req0[2] = 1'b1;
        isol0[2*NP +: NP] = 4'hF;
        tick();
        tick();
        repeat (GD) tick();
        req0[2] = 1'b0;
        repeat (4) tick();
        cmp("pre_reset_wake", 64'(st0[6 +: 3]), 64'(4));
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_model();
        cmp("async_rst_n",  64'(rstn0), 64'({NC{1'b1}}));
        cmp("async_clk_en", 64'(en0),   64'({NC{1'b1}}));
        check_boot();
        isol0 = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
            check_model();
        end
        #2 rst_n = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < NC; c++) begin
                if ($urandom_range(0, 15) == 0) req0[c] = ~req0[c];
                if ($urandom_range(0, 63) == 0) stuck[c] = ~stuck[c];
                for (int b = 0; b < NP; b++) begin
                    if ($urandom_range(0, 7) != 0) isol0[c*NP + b] = if0.port_isolate[c*NP + b];
                    else                           isol0[c*NP + b] = 1'($urandom_range(0, 1));
                end
                if (stuck[c]) isol0[c*NP] = 1'b0;
                clr0[c] = ($urandom_range(0, 15) == 0);
            end
            tick();
        end
        check_boot();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/chimera_clu_iso_ctrl.md
Name: chimera_clu_iso_ctrl

Overview:
- Per-cluster isolation, clock-gate and reset sequencer for the cluster domain.
- Generalised to NumClusters clusters, each with NumPorts AXI isolation ports (narrow-in, narrow-out pair, wide, ...).
- Drives the isolate_i of each port's axi_isolate and collects its isolated_o.
- Sequences drain -> clock gate -> hold reset -> wake, with drain timeout detection; this is behaviour a static isolate/AND wrapper lacks.

Parameters:
- NumClusters, 5, number of clusters sequenced.
- NumPorts, 4, isolation ports per cluster.
- DrainTimeout, 1024, cycles in DRAIN before the timeout flag sets; 0 disables.
- GateDelay, 4, cycles held in ISOLATED before the clock is gated; >=1.
- ResetCycles, 8, cycles the clock runs with reset asserted during wake; >=1.
- BootIsolated, 0, 1 = every cluster leaves reset in GATED.

Ports:
- soc_clk_i  in  1  SoC clock; single clock domain.
- rst_ni  in  1  reset, asynchronous, active-low.
- iso_req_i  in  NumClusters  level request; 1 = isolate and power down the cluster, 0 = run.
- port_isolated_i  in  NumClusters*NumPorts  isolated_o of each axi_isolate; cluster c owns bits [c*NumPorts +: NumPorts].
- port_isolate_o  out  NumClusters*NumPorts  isolate_i to each axi_isolate.
- clu_clk_en_o  out  NumClusters  clock-gate enable per cluster.
- clu_rst_no  out  NumClusters  cluster reset, active-low.
- state_o  out  3*NumClusters  FSM state per cluster, encoded as listed under Behaviour.
- timeout_o  out  NumClusters  sticky drain-timeout flag.
- timeout_clr_i  in  NumClusters  1-cycle clear of timeout_o.
- irq_o  out  1  timeout interrupt; see Optional Feature.

Behaviour:
- Independent FSM per cluster, all outputs registered.
- States and encoding: ACTIVE=0, DRAIN=1, ISOLATED=2, GATED=3, WAKE=4, RELEASE=5.
- Reset (BootIsolated=0): state ACTIVE, port_isolate_o=0, clu_clk_en_o=1, clu_rst_no=1, timeout_o=0, counter=0.
- Reset (BootIsolated=1): state GATED, port_isolate_o=1, clu_clk_en_o=0, clu_rst_no=0.
- ACTIVE: iso_req=1 -> DRAIN; port_isolate_o for the cluster = all ones from the next cycle.
- DRAIN:
  - All NumPorts isolated bits = 1 -> ISOLATED and counter cleared. The cycle an all-ones value is sampled counts; no extra latency.
  - Counter increments each cycle. When the counter reaches DrainTimeout-1, timeout_o sets; the FSM stays in DRAIN (no forced gating).
  - iso_req drops -> RELEASE. If iso_req drops in the same cycle all ports report isolated, RELEASE wins.
- ISOLATED: counts GateDelay cycles -> GATED. iso_req dropping here -> RELEASE with clock still running and no reset.
- GATED: clu_clk_en_o=0 and clu_rst_no=0 from the entry cycle; isolate held. iso_req=0 -> WAKE.
- WAKE: clu_clk_en_o=1, clu_rst_no=0 for ResetCycles cycles -> RELEASE. iso_req=1 is ignored until RELEASE.
- RELEASE:
  - clu_rst_no=1 and port_isolate_o=0 from the entry cycle.
  - All isolated bits = 0 -> ACTIVE.
  - iso_req=1 -> DRAIN immediately, re-asserting isolate.
- Counter width: $clog2(max(DrainTimeout, GateDelay, ResetCycles)+1); cleared on every state change; saturates, never wraps.
- timeout_o:
  - Set has priority over a simultaneous timeout_clr_i.
  - The set fires only once per DRAIN visit.
  - Clear is independent of state.
- An async reset mid-sequence returns every output to its reset value immediately.

Optional Feature:
- Macro CHIMERA_CLU_ISO_IRQ_EN.
- Defined: irq_o = registered OR of timeout_o; it rises 1 cycle after any flag sets and falls 1 cycle after all flags clear.
- Undefined: irq_o tied 0, no extra flops.

Decomposition:
- chimera_pkg gets:
  - clu_iso_state_e, a 3-bit enum with the encoding above.
  - CluIsoStateWidth = 3.
- Sub-module chimera_clu_iso_fsm: one cluster's FSM, counter and timeout flag, instantiated in a generate loop over NumClusters.
- The top level does the port slicing and the optional irq reduction.

Test Plan:
- Reset, BootIsolated=0, NumPorts=4 -> all clusters state 0, clk_en=1, rst_no=1, isolate=0.
- Cluster 2 iso_req=1; isolated bits return 4'b1111 after 5 cycles -> state sequence 1,2 (GateDelay=4 cycles),3; clk_en=0 and rst_no=0 on GATED entry; other clusters unaffected.
- From GATED, iso_req=0 -> WAKE for 8 cycles with clk_en=1, rst_no=0; then RELEASE with isolate=0; isolated bits go 0 -> ACTIVE.
- DrainTimeout=16, isolated bits stuck 4'b0111 -> timeout_o[c]=1 after exactly 16 DRAIN cycles, state stays 1; irq_o=1 next cycle (macro on); timeout_clr_i pulse -> flag 0.
- iso_req drops in DRAIN on the same cycle isolated bits reach 4'b1111 -> RELEASE; no clock gating or reset glitch.
- Async reset asserted in WAKE -> outputs at reset values in the same cycle; BootIsolated=1 run -> all clusters start in GATED.
